// File: rtl/ex_stage.sv
// ex_stage: execute stage -- ALU, load/store address, branch/jump resolution, registered output bank.
// Define EX_MUL_EN to compile in the iterative shift-add multiplier (op 10) and its busy states.
package ex_stage_pkg;
    typedef logic [1:0] access_size_t;
endpackage

module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REGISTER_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  logic                      stall_i,
    input  logic [ADDR_WIDTH-1:0]     pc_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [DATA_WIDTH-1:0]     imm_i,
    input  logic                      use_imm_i,
    input  logic [3:0]                alu_op_i,
    input  logic                      is_branch_i,
    input  logic                      is_jump_i,
    input  logic                      is_load_i,
    input  logic                      is_store_i,
    input  logic                      reg_wr_en_i,
    input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
    input  access_size_t              access_size_i,
    output logic                      stall_o,
    output logic                      mem_valid_o,
    output logic                      mem_is_load_o,
    output logic                      mem_is_store_o,
    output logic                      mem_reg_wr_en_o,
    output logic [DATA_WIDTH-1:0]     mem_alu_result_o,
    output logic [DATA_WIDTH-1:0]     mem_rs2_data_o,
    output logic [REGISTER_WIDTH-1:0] mem_wr_reg_o,
    output access_size_t              mem_access_size_o,
    output logic                      branch_taken_o,
    output logic [ADDR_WIDTH-1:0]     branch_target_o
);
    localparam int unsigned SHW   = $clog2(DATA_WIDTH);
    localparam int unsigned CNT_W = SHW + 1;

    typedef enum logic [1:0] {READY, MUL_BUSY, MUL_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic                  w_accept;
    logic                  w_is_mul;
    logic [DATA_WIDTH-1:0] w_opb;
    logic [SHW-1:0]        w_shamt;
    logic                  w_br_eq;
    logic                  w_br_lt;
    logic                  w_br_cond;
    logic [DATA_WIDTH-1:0] w_alu;
    logic [DATA_WIDTH-1:0] w_result;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_taken;

    assign w_opb    = use_imm_i ? imm_i : rs2_data_i;
    assign w_shamt  = w_opb[SHW-1:0];
    assign w_accept = valid_i & ~stall_i & (r_state == READY);
    assign stall_o  = stall_i | (r_state != READY);

`ifdef EX_MUL_EN
    assign w_is_mul = (alu_op_i == 4'd10);
`else
    assign w_is_mul = 1'b0;
`endif

    // Branch compares always use rs2, independent of use_imm_i (imm feeds the target).
    assign w_br_eq = (rs1_data_i == rs2_data_i);
    assign w_br_lt = ($signed(rs1_data_i) < $signed(rs2_data_i));

    always_comb begin
        w_br_cond = 1'b0;
        case (alu_op_i)
            4'd11:   w_br_cond = w_br_eq;
            4'd12:   w_br_cond = ~w_br_eq;
            4'd13:   w_br_cond = w_br_lt;
            4'd14:   w_br_cond = ~w_br_lt;
            default: w_br_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (alu_op_i)
            4'd0:    w_alu = rs1_data_i + w_opb;
            4'd1:    w_alu = rs1_data_i - w_opb;
            4'd2:    w_alu = rs1_data_i & w_opb;
            4'd3:    w_alu = rs1_data_i | w_opb;
            4'd4:    w_alu = rs1_data_i ^ w_opb;
            4'd5:    w_alu = rs1_data_i << w_shamt;
            4'd6:    w_alu = rs1_data_i >> w_shamt;
            4'd7:    w_alu = $unsigned($signed(rs1_data_i) >>> w_shamt);
            4'd8:    w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1_data_i) < $signed(w_opb))};
            4'd9:    w_alu = {{(DATA_WIDTH-1){1'b0}}, (rs1_data_i < w_opb)};
            4'd11,
            4'd12,
            4'd13,
            4'd14:   w_alu = {{(DATA_WIDTH-1){1'b0}}, w_br_cond};
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_result = w_alu;
        if (is_jump_i)
            w_result = DATA_WIDTH'(pc_i + ADDR_WIDTH'(4));
        else if (is_load_i | is_store_i)
            w_result = rs1_data_i + imm_i;
    end

    assign w_target = pc_i + ADDR_WIDTH'(imm_i);
    assign w_taken  = is_jump_i | (is_branch_i & w_br_cond);

`ifdef EX_MUL_EN
    logic [DATA_WIDTH-1:0]     r_mcand;
    logic [DATA_WIDTH-1:0]     r_mplier;
    logic [DATA_WIDTH-1:0]     r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic [DATA_WIDTH-1:0]     r_mul_rs2;
    logic [REGISTER_WIDTH-1:0] r_mul_wr_reg;
    logic                      r_mul_wr_en;
    access_size_t              r_mul_size;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_mul_rs2    <= '0;
            r_mul_wr_reg <= '0;
            r_mul_wr_en  <= 1'b0;
            r_mul_size   <= '0;
        end else if (!stall_i) begin
            if (w_accept && w_is_mul) begin
                r_mcand      <= rs1_data_i;
                r_mplier     <= w_opb;
                r_acc        <= '0;
                r_cnt        <= '0;
                r_mul_rs2    <= rs2_data_i;
                r_mul_wr_reg <= wr_reg_i;
                r_mul_wr_en  <= reg_wr_en_i;
                r_mul_size   <= access_size_i;
            end else if (r_state == MUL_BUSY) begin
                if (r_mplier[0])
                    r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end
`endif

    always_comb begin
        w_state_nx = r_state;
`ifdef EX_MUL_EN
        if (!stall_i) begin
            case (r_state)
                READY:    if (w_accept && w_is_mul) w_state_nx = MUL_BUSY;
                MUL_BUSY: if (r_cnt == CNT_W'(DATA_WIDTH - 1)) w_state_nx = MUL_DONE;
                MUL_DONE: w_state_nx = READY;
                default:  w_state_nx = READY;
            endcase
        end
`else
        w_state_nx = READY;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= READY;
        else
            r_state <= w_state_nx;
    end

    // Bubbles clear only the qualifying controls; data fields keep their last value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_valid_o       <= 1'b0;
            mem_is_load_o     <= 1'b0;
            mem_is_store_o    <= 1'b0;
            mem_reg_wr_en_o   <= 1'b0;
            mem_alu_result_o  <= '0;
            mem_rs2_data_o    <= '0;
            mem_wr_reg_o      <= '0;
            mem_access_size_o <= '0;
            branch_taken_o    <= 1'b0;
            branch_target_o   <= '0;
        end else if (!stall_i) begin
            mem_valid_o     <= 1'b0;
            mem_is_load_o   <= 1'b0;
            mem_is_store_o  <= 1'b0;
            mem_reg_wr_en_o <= 1'b0;
            branch_taken_o  <= 1'b0;
            if (w_accept && !w_is_mul) begin
                mem_valid_o       <= 1'b1;
                mem_is_load_o     <= is_load_i;
                mem_is_store_o    <= is_store_i;
                mem_reg_wr_en_o   <= reg_wr_en_i & ~is_branch_i;
                mem_alu_result_o  <= w_result;
                mem_rs2_data_o    <= rs2_data_i;
                mem_wr_reg_o      <= wr_reg_i;
                mem_access_size_o <= access_size_i;
                branch_taken_o    <= w_taken;
                branch_target_o   <= w_target;
            end
`ifdef EX_MUL_EN
            else if (r_state == MUL_DONE) begin
                mem_valid_o       <= 1'b1;
                mem_reg_wr_en_o   <= r_mul_wr_en;
                mem_alu_result_o  <= r_acc;
                mem_rs2_data_o    <= r_mul_rs2;
                mem_wr_reg_o      <= r_mul_wr_reg;
                mem_access_size_o <= r_mul_size;
            end
`endif
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage with a scoreboard of expected output-bank contents.
// Multiply timing checks are compiled only when EX_MUL_EN is defined.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, stall_i, use_imm_i;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [3:0]  alu_op_i;
    logic        is_branch_i, is_jump_i, is_load_i, is_store_i, reg_wr_en_i;
    logic [4:0]  wr_reg_i;
    access_size_t access_size_i;
    logic        stall_o, mem_valid_o, mem_is_load_o, mem_is_store_o, mem_reg_wr_en_o;
    logic [31:0] mem_alu_result_o, mem_rs2_data_o, branch_target_o;
    logic [4:0]  mem_wr_reg_o;
    access_size_t mem_access_size_o;
    logic        branch_taken_o;

    ex_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REGISTER_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .use_imm_i(use_imm_i), .alu_op_i(alu_op_i),
        .is_branch_i(is_branch_i), .is_jump_i(is_jump_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .reg_wr_en_i(reg_wr_en_i), .wr_reg_i(wr_reg_i),
        .access_size_i(access_size_i), .stall_o(stall_o),
        .mem_valid_o(mem_valid_o), .mem_is_load_o(mem_is_load_o),
        .mem_is_store_o(mem_is_store_o), .mem_reg_wr_en_o(mem_reg_wr_en_o),
        .mem_alu_result_o(mem_alu_result_o), .mem_rs2_data_o(mem_rs2_data_o),
        .mem_wr_reg_o(mem_wr_reg_o), .mem_access_size_o(mem_access_size_o),
        .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic        chk_res;
        logic [31:0] res;
        logic        taken;
        logic [31:0] tgt;
        logic        ld;
        logic        we;
        logic [4:0]  wr_reg;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        valid_i = 1'b0; use_imm_i = 1'b0; alu_op_i = '0; pc_i = '0;
        rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
        is_branch_i = 1'b0; is_jump_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
        reg_wr_en_i = 1'b0; wr_reg_i = '0; access_size_i = '0;
    endtask

    // flags = {branch, jump, load, store, reg_wr_en}
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic ui, input logic [31:0] pc,
                         input logic [4:0] flags, input logic [4:0] rd);
        valid_i = 1'b1; alu_op_i = op; rs1_data_i = a; rs2_data_i = b; imm_i = imm;
        use_imm_i = ui; pc_i = pc;
        {is_branch_i, is_jump_i, is_load_i, is_store_i, reg_wr_en_i} = flags;
        wr_reg_i = rd; access_size_i = 2'd2;
    endtask

    task automatic push(input string tag, input logic chk_res, input logic [31:0] res,
                        input logic taken, input logic [31:0] tgt, input logic ld,
                        input logic we, input logic [4:0] rd);
        exp_t e;
        e.tag = tag; e.chk_res = chk_res; e.res = res; e.taken = taken; e.tgt = tgt;
        e.ld = ld; e.we = we; e.wr_reg = rd;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_vec++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_underflow observed=0 expected=1 entries");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp({e.tag, "_valid"}, 32'(mem_valid_o), 32'd1);
            if (e.chk_res) cmp({e.tag, "_res"}, mem_alu_result_o, e.res);
            cmp({e.tag, "_taken"}, 32'(branch_taken_o), 32'(e.taken));
            if (e.taken) cmp({e.tag, "_tgt"}, branch_target_o, e.tgt);
            cmp({e.tag, "_ld"}, 32'(mem_is_load_o), 32'(e.ld));
            cmp({e.tag, "_we"}, 32'(mem_reg_wr_en_o), 32'(e.we));
            cmp({e.tag, "_rd"}, 32'(mem_wr_reg_o), 32'(e.wr_reg));
        end
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_valid"}, 32'(mem_valid_o), 32'd0);
        cmp({tag, "_res"}, mem_alu_result_o, 32'd0);
        cmp({tag, "_taken"}, 32'(branch_taken_o), 32'd0);
        cmp({tag, "_tgt"}, branch_target_o, 32'd0);
        cmp({tag, "_ctl"}, 32'({mem_is_load_o, mem_is_store_o, mem_reg_wr_en_o}), 32'd0);
        cmp({tag, "_stall"}, 32'(stall_o), 32'd0);
    endtask

    initial begin
        idle();
        stall_i = 1'b0;
        rst_i   = 1'b1;
        tick(); tick();
        check_zero("reset");
        rst_i = 1'b0;
        tick();
        cmp("post_reset_stall", 32'(stall_o), 32'd0);
`ifdef EX_MUL_EN
        // Start a multiply, then reset it away mid-flight.
        drive(4'd10, 32'h0000_FFFF, 32'h0001_0001, '0, 1'b0, '0, 5'b00001, 5'd3);
        tick();
        idle();
        tick(); tick();
        cmp("mul_busy_stall", 32'(stall_o), 32'd1);
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        check_zero("reset_mid_mul");
`endif
        // ADD then an ALU sweep issued back to back.
        drive(4'd0, 32'd3, 32'd4, '0, 1'b0, '0, 5'b00001, 5'd1);
        push("add", 1'b1, 32'd7, 1'b0, '0, 1'b0, 1'b1, 5'd1);
        tick();
        drive(4'd1, 32'h0, 32'h1, '0, 1'b0, '0, 5'b00001, 5'd2);
        push("sub", 1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, 1'b1, 5'd2);
        pop_check();
        tick();
        drive(4'd7, 32'h8000_0000, '0, 32'd4, 1'b1, '0, 5'b00001, 5'd3);
        push("sra", 1'b1, 32'hF800_0000, 1'b0, '0, 1'b0, 1'b1, 5'd3);
        pop_check();
        tick();
        drive(4'd8, 32'hFFFF_FFFF, 32'd1, '0, 1'b0, '0, 5'b00001, 5'd4);
        push("slt", 1'b1, 32'd1, 1'b0, '0, 1'b0, 1'b1, 5'd4);
        pop_check();
        tick();
        drive(4'd9, 32'hFFFF_FFFF, 32'd1, '0, 1'b0, '0, 5'b00001, 5'd5);
        push("sltu", 1'b1, 32'd0, 1'b0, '0, 1'b0, 1'b1, 5'd5);
        pop_check();
        tick();
        drive(4'd5, 32'h0000_0003, 32'd31, '0, 1'b0, '0, 5'b00001, 5'd6);
        push("sll", 1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, 1'b1, 5'd6);
        pop_check();
        tick();
        // Load address rs1 + imm, then stall_i holds the bank for 3 cycles.
        drive(4'd0, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b1, '0, 5'b00101, 5'd7);
        push("load", 1'b1, 32'h0000_00FC, 1'b0, '0, 1'b1, 1'b1, 5'd7);
        pop_check();
        tick();
        pop_check();
        cmp("load_rs2", mem_rs2_data_o, 32'hDEAD_BEEF);
        drive(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, '0, 1'b0, '0, 5'b00001, 5'd8);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("hold_res", mem_alu_result_o, 32'h0000_00FC);
            cmp("hold_valid", 32'(mem_valid_o), 32'd1);
            cmp("hold_ld", 32'(mem_is_load_o), 32'd1);
            cmp("hold_stall_o", 32'(stall_o), 32'd1);
        end
        stall_i = 1'b0;
        push("xor", 1'b1, 32'hFF00_FF00, 1'b0, '0, 1'b0, 1'b1, 5'd8);
        tick();
        // BNE taken is a single-cycle pulse; BEQ on the same operands is not taken.
        drive(4'd12, 32'd5, 32'd6, 32'h20, 1'b0, 32'h40, 5'b10001, 5'd9);
        push("bne", 1'b0, '0, 1'b1, 32'h60, 1'b0, 1'b0, 5'd9);
        pop_check();
        tick();
        idle();
        pop_check();
        tick();
        cmp("bne_pulse_end", 32'(branch_taken_o), 32'd0);
        cmp("bubble_valid", 32'(mem_valid_o), 32'd0);
        drive(4'd11, 32'd5, 32'd6, 32'h20, 1'b0, 32'h40, 5'b10001, 5'd9);
        push("beq", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 5'd9);
        tick();
        drive(4'd0, '0, '0, 32'h40, 1'b1, 32'h100, 5'b01001, 5'd1);
        push("jal", 1'b1, 32'h104, 1'b1, 32'h140, 1'b0, 1'b1, 5'd1);
        pop_check();
        tick();
        idle();
        pop_check();
        tick();
`ifdef EX_MUL_EN
        begin
            int n;
            for (int pass = 0; pass < 2; pass++) begin
                drive(4'd10, 32'h0000_FFFF, 32'h0001_0001, '0, 1'b0, '0, 5'b00001, 5'd12);
                push(pass == 0 ? "mul" : "mul_stall", 1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, 1'b1, 5'd12);
                tick();
                idle();
                n = 0;
                while (n < 100) begin
                    tick();
                    n++;
                    if (pass == 1 && n == 5) stall_i = 1'b1;
                    if (pass == 1 && n == 7) stall_i = 1'b0;
                    if (mem_valid_o) break;
                    if (n == 1 || n == 31) cmp("mul_busy_stall_o", 32'(stall_o), 32'd1);
                end
                cmp(pass == 0 ? "mul_latency" : "mul_stall_latency", 32'(n), pass == 0 ? 32'd33 : 32'd35);
                pop_check();
                cmp("mul_done_stall_o", 32'(stall_o), 32'd0);
            end
        end
`else
        drive(4'd10, 32'd3, 32'd4, '0, 1'b0, '0, 5'b00001, 5'd12);
        push("mul_off", 1'b1, 32'd0, 1'b0, '0, 1'b0, 1'b1, 5'd12);
        #1;
        cmp("mul_off_stall_pre", 32'(stall_o), 32'd0);
        tick();
        idle();
        pop_check();
        cmp("mul_off_stall_post", 32'(stall_o), 32'd0);
        tick();
        cmp("mul_off_stall_late", 32'(stall_o), 32'd0);
`endif
        cmp("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
